// File: rtl/jpeg_quantizer.sv
// JPEG luminance quantizer: 8 signed DCT coefficients per beat, one block row per beat.
// Two-stage pipeline: magnitude/sign capture, then reciprocal multiply with rounding.
module jpeg_quantizer #(
  parameter int DATA_W  = 12,
  parameter int RECIP_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_valid,
  input  logic                i_sof,
  input  logic [8*DATA_W-1:0] i_data,
  output logic                o_valid,
  output logic [8*DATA_W-1:0] o_data,
  output logic [2:0]          o_row,
  output logic                o_last,
  output logic                o_sync_err
);

  localparam int ABS_W  = DATA_W + 1;
  localparam int PROD_W = DATA_W + RECIP_W + 1;
  localparam logic [PROD_W-1:0] HALF = PROD_W'(1) << (RECIP_W - 1);

  localparam int Q_LUMA [0:63] = '{
    16,  11,  10,  16,  24,  40,  51,  61,
    12,  12,  14,  19,  26,  58,  60,  55,
    14,  13,  16,  24,  40,  57,  69,  56,
    14,  17,  22,  29,  51,  87,  80,  62,
    18,  22,  37,  56,  68, 109, 103,  77,
    24,  35,  55,  64,  81, 104, 113,  92,
    49,  64,  78,  87, 103, 121, 120, 101,
    72,  92,  95,  98, 112, 100, 103,  99
  };

  logic [RECIP_W-1:0] recip_rom_s [0:63];

  // Reciprocal ROM: round(2^RECIP_W / Q) evaluated at elaboration, so only constants remain.
  genvar gi;
  generate
    for (gi = 0; gi < 64; gi++) begin : g_rom
      localparam int RV = ((1 << (RECIP_W + 1)) + Q_LUMA[gi]) / (2 * Q_LUMA[gi]);
      assign recip_rom_s[gi] = RV[RECIP_W-1:0];
    end
  endgenerate

  logic [2:0]                row_cnt_r;
  logic [2:0]                row_idx_s;
  logic                      sync_err_s;
  logic [7:0][ABS_W-1:0]     abs_s;
  logic [7:0]                neg_s;

  logic [7:0][ABS_W-1:0]     abs_r;
  logic [7:0]                neg_r;
  logic [2:0]                row1_r;
  logic                      v1_r;
  logic                      err1_r;

  logic [7:0][PROD_W-1:0]    sum_s;
  logic [7:0][DATA_W-1:0]    q_s;

  // Row selection, sync check and per-lane magnitude/sign of the incoming beat.
  always_comb begin
    row_idx_s  = i_sof ? 3'd0 : row_cnt_r;
    sync_err_s = i_valid & i_sof & (row_cnt_r != 3'd0);
    abs_s      = '0;
    neg_s      = '0;
    for (int k = 0; k < 8; k++) begin
      neg_s[k] = i_data[k*DATA_W + DATA_W - 1];
      if (neg_s[k]) begin
        abs_s[k] = {ABS_W{1'b0}} - {1'b1, i_data[k*DATA_W +: DATA_W]};
      end else begin
        abs_s[k] = {1'b0, i_data[k*DATA_W +: DATA_W]};
      end
    end
  end

  // Row counter: next row follows the index actually used, wrapping 7 -> 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_cnt_r <= 3'd0;
    end else if (i_valid) begin
      row_cnt_r <= row_idx_s + 3'd1;
    end
  end

  // Stage 1: capture magnitude, sign, row index and the sync-error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      abs_r  <= '0;
      neg_r  <= '0;
      row1_r <= 3'd0;
      v1_r   <= 1'b0;
      err1_r <= 1'b0;
    end else begin
      v1_r   <= i_valid;
      err1_r <= sync_err_s;
      if (i_valid) begin
        abs_r  <= abs_s;
        neg_r  <= neg_s;
        row1_r <= row_idx_s;
      end
    end
  end

  // Multiply by the row/lane reciprocal, round half up, shift, and restore the sign.
  always_comb begin
    sum_s = '0;
    q_s   = '0;
    for (int k = 0; k < 8; k++) begin
      sum_s[k] = PROD_W'(abs_r[k]) * PROD_W'(recip_rom_s[{row1_r, 3'(k)}]) + HALF;
      if (neg_r[k]) begin
        q_s[k] = {DATA_W{1'b0}} - DATA_W'(sum_s[k] >> RECIP_W);
      end else begin
        q_s[k] = DATA_W'(sum_s[k] >> RECIP_W);
      end
    end
  end

  // Stage 2: output registers; data and row hold while no beat is emitted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_valid    <= 1'b0;
      o_data     <= '0;
      o_row      <= 3'd0;
      o_last     <= 1'b0;
      o_sync_err <= 1'b0;
    end else begin
      o_valid    <= v1_r;
      o_last     <= v1_r & (row1_r == 3'd7);
      o_sync_err <= v1_r & err1_r;
      if (v1_r) begin
        o_data <= q_s;
        o_row  <= row1_r;
      end
    end
  end

endmodule

// File: tb/tb_jpeg_quantizer.sv
// Self-checking bench for jpeg_quantizer: directed spec scenarios plus random traffic
// compared against an arithmetic reference model with an expected-output queue.
module tb_jpeg_quantizer;

  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_valid;
  logic          i_sof;
  logic [8*DW-1:0] i_data;
  logic          o_valid;
  logic [8*DW-1:0] o_data;
  logic [2:0]    o_row;
  logic          o_last;
  logic          o_sync_err;

  jpeg_quantizer dut (
    .clk        (clk),
    .reset      (reset),
    .i_valid    (i_valid),
    .i_sof      (i_sof),
    .i_data     (i_data),
    .o_valid    (o_valid),
    .o_data     (o_data),
    .o_row      (o_row),
    .o_last     (o_last),
    .o_sync_err (o_sync_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int          cyc;
    int          row;
    logic        last;
    logic        err;
    logic [95:0] data;
  } rec_t;

  int QT [64] = '{
    16,  11,  10,  16,  24,  40,  51,  61,
    12,  12,  14,  19,  26,  58,  60,  55,
    14,  13,  16,  24,  40,  57,  69,  56,
    14,  17,  22,  29,  51,  87,  80,  62,
    18,  22,  37,  56,  68, 109, 103,  77,
    24,  35,  55,  64,  81, 104, 113,  92,
    49,  64,  78,  87, 103, 121, 120, 101,
    72,  92,  95,  98, 112, 100, 103,  99
  };

  rec_t exp_q [$];
  rec_t obs_q [$];
  int   cyc = 0;
  int   m_row = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   idle_viol = 0;
  int   hold_viol = 0;
  logic [95:0] prev_data = '0;
  logic [2:0]  prev_row = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor: records every output beat and flags idle-cycle misbehaviour.
  always @(negedge clk) begin
    rec_t r;
    if (!reset) begin
      if (o_valid) begin
        r.cyc = cyc; r.row = int'(o_row); r.last = o_last; r.err = o_sync_err; r.data = o_data;
        obs_q.push_back(r);
      end else begin
        if (o_last || o_sync_err) idle_viol++;
        if (o_data !== prev_data || o_row !== prev_row) hold_viol++;
      end
    end
    prev_data = o_data;
    prev_row  = o_row;
  end

  function automatic int quant(int c, int r, int k);
    int rc, a, m;
    rc = $rtoi(65536.0 / real'(QT[r*8+k]) + 0.5);
    a  = (c < 0) ? -c : c;
    m  = (a * rc + 32768) / 65536;
    return (c < 0) ? -m : m;
  endfunction

  function automatic logic [95:0] rnd_data();
    logic [95:0] d;
    for (int k = 0; k < 8; k++) begin
      case ($urandom_range(0, 7))
        0:       d[k*DW +: DW] = 12'h800;
        1:       d[k*DW +: DW] = 12'h7FF;
        2:       d[k*DW +: DW] = 12'h000;
        default: d[k*DW +: DW] = 12'($urandom());
      endcase
    end
    return d;
  endfunction

  // Drive one cycle of input; accepted beats go into the reference model.
  task automatic beat(input bit v, input bit s, input logic [95:0] d);
    rec_t e;
    int idx;
    logic signed [DW-1:0] ln;
    @(negedge clk);
    i_valid = v; i_sof = s; i_data = d;
    if (v) begin
      idx    = s ? 0 : m_row;
      e.cyc  = cyc + 2;
      e.row  = idx;
      e.last = (idx == 7);
      e.err  = s && (m_row != 0);
      for (int k = 0; k < 8; k++) begin
        ln = d[k*DW +: DW];
        e.data[k*DW +: DW] = DW'(quant(int'(ln), idx, k));
      end
      m_row = (idx + 1) % 8;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      i_valid = 1'b0;
      i_sof   = 1'($urandom());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; i_valid = 1'b1; i_sof = 1'b1; i_data = rnd_data();
    repeat (3) @(negedge clk);
    n_tests++;
    if ({o_valid, o_data, o_row, o_last, o_sync_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%0b row=%0d last=%0b err=%0b data=%h, expected all zero",
               o_valid, o_row, o_last, o_sync_err, o_data);
    end
    i_valid = 1'b0; i_sof = 1'b0; reset = 1'b0;
    idle(3);
    n_tests++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_no_output: got %0d beats, expected 0", obs_q.size());
    end
    obs_q.delete(); exp_q.delete(); m_row = 0;
    beat(1'b1, 1'b0, rnd_data());
    idle(4);
    n_tests++;
    if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      n_fail++;
      $display("FAIL reset_first_row: got %0d beats (first %h), expected %h",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : '0, exp_q[0]);
    end
  endtask

  task automatic test_basic();
    logic [11:0] in0  [5] = '{12'd100, -12'sd100, 12'd2047, 12'h800, 12'd0};
    logic [11:0] want [5] = '{12'd6, -12'sd6, 12'd128, -12'sd128, 12'd0};
    logic [95:0] d;
    rec_t r;
    obs_q.delete(); exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      d = rnd_data(); d[11:0] = in0[i];
      beat(1'b1, 1'b1, d);
    end
    idle(4);
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL basic_count: got %0d beats, expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL basic_beat%0d: got %h, expected %h", i, obs_q[i], exp_q[i]);
      end
      r = obs_q[i];
      n_tests++;
      if (r.data[11:0] !== want[i] || r.row != 0) begin
        n_fail++;
        $display("FAIL basic_lane0_%0d: got %0d row %0d, expected %0d row 0",
                 i, $signed(r.data[11:0]), r.row, $signed(want[i]));
      end
    end
  endtask

  task automatic test_full_block();
    logic [95:0] d;
    rec_t r;
    int nlast;
    obs_q.delete(); exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      d = rnd_data();
      if (i == 7) d[95:84] = 12'd99;
      beat(1'b1, i == 0, d);
    end
    idle(4);
    n_tests++;
    if (obs_q.size() != 8) begin
      n_fail++;
      $display("FAIL block_count: got %0d beats, expected 8", obs_q.size());
    end
    nlast = 0;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL block_beat%0d: got %h, expected %h", i, obs_q[i], exp_q[i]);
      end
      r = obs_q[i];
      if (r.last) nlast++;
      if (i == 7) begin
        n_tests++;
        if (r.data[95:84] !== 12'd1 || !r.last || r.row != 7 || r.err) begin
          n_fail++;
          $display("FAIL block_row7: got lane7=%0d last=%0b row=%0d err=%0b, expected 1 1 7 0",
                   $signed(r.data[95:84]), r.last, r.row, r.err);
        end
      end
    end
    n_tests++;
    if (nlast != 1) begin
      n_fail++;
      $display("FAIL block_last_count: got %0d, expected 1", nlast);
    end
  endtask

  task automatic test_resync();
    obs_q.delete(); exp_q.delete();
    for (int i = 0; i < 7; i++) beat(1'b1, (i == 0) || (i == 3), rnd_data());
    idle(4);
    n_tests++;
    if (obs_q.size() != 7) begin
      n_fail++;
      $display("FAIL resync_count: got %0d beats, expected 7", obs_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i] || (i == 3 && (!obs_q[i].err || obs_q[i].row != 0))) begin
        n_fail++;
        $display("FAIL resync_beat%0d: got %h, expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_q.delete(); exp_q.delete();
    beat(1'b1, 1'b1, rnd_data());
    beat(1'b1, 1'b0, rnd_data());
    beat(1'b1, 1'b0, rnd_data());
    #2 reset = 1'b1;
    while (exp_q.size() > 0 && exp_q[$].cyc > cyc) void'(exp_q.pop_back());
    m_row = 0;
    #1;
    n_tests++;
    if ({o_valid, o_data, o_row, o_last, o_sync_err} !== '0) begin
      n_fail++;
      $display("FAIL midreset_clear: got v=%0b row=%0d data=%h, expected all zero", o_valid, o_row, o_data);
    end
    repeat (2) @(negedge clk);
    i_valid = 1'b0; i_sof = 1'b0; reset = 1'b0;
    beat(1'b1, 1'b0, rnd_data());
    idle(4);
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL midreset_count: got %0d beats, expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL midreset_beat%0d: got %h, expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_gapped();
    obs_q.delete(); exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) beat(1'b1, i == 0, rnd_data());
      else            beat(1'b0, 1'($urandom()), rnd_data());
    end
    idle(4);
    n_tests++;
    if (obs_q.size() != 8) begin
      n_fail++;
      $display("FAIL gapped_count: got %0d beats, expected 8", obs_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL gapped_beat%0d: got %h, expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int errs;
    obs_q.delete(); exp_q.delete();
    for (int i = 0; i < 300; i++) beat(($urandom() % 4) != 0, ($urandom() % 8) == 0, rnd_data());
    idle(4);
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL random_count: got %0d beats, expected %0d", obs_q.size(), exp_q.size());
    end
    errs = 0;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        if (errs < 5) $display("FAIL random_beat%0d: got %h, expected %h", i, obs_q[i], exp_q[i]);
        errs++;
      end
    end
  endtask

  task automatic test_idle_outputs();
    n_tests++;
    if (idle_viol != 0 || hold_viol != 0) begin
      n_fail++;
      $display("FAIL idle_outputs: got %0d last/err and %0d hold violations, expected 0 and 0",
               idle_viol, hold_viol);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_full_block();
    test_resync();
    test_reset_mid();
    test_gapped();
    test_back_to_back();
    test_idle_outputs();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
